// File: rtl/prbs31_checker.sv
// PRBS31 (x^31 + x^28 + 1) bit-error checker with HUNT/SYNC/LOCKED acquisition and windowed loss-of-lock.
// Optional bit counter enabled by defining PRBS31_CHECKER_BITCNT_EN.
module prbs31_checker #(
  parameter int unsigned LOCK_CNT  = 64,
  parameter int unsigned ERR_LIMIT = 8,
  parameter int unsigned WINDOW    = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic        rx_bit,
  input  logic        clear_err,
  output logic        locked,
  output logic [1:0]  state,
  output logic        err_pulse,
  output logic [15:0] err_count,
  output logic [31:0] bit_count
);

  localparam int unsigned WIN_W     = $clog2(WINDOW);
  localparam logic [7:0]  LOCK_LAST = 8'(LOCK_CNT - 1);
  localparam logic [7:0]  ERR_LAST  = 8'(ERR_LIMIT - 1);

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_SYNC   = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t             r_state, w_state_next;
  logic [30:0]        r_sr, w_sr_next;
  logic [4:0]         r_fill_cnt, w_fill_cnt_next;
  logic [7:0]         r_match_cnt, w_match_cnt_next;
  logic [WIN_W-1:0]   r_win_cnt, w_win_cnt_next;
  logic [7:0]         r_err_win, w_err_win_next;
  logic               r_err_pulse, w_err_pulse_next;
  logic [15:0]        r_err_count, w_err_count_next;

  logic               w_pred;
  logic               w_err;
  logic [30:0]        w_sr_rx;
  logic               w_win_wrap;

  assign w_pred     = r_sr[27] ^ r_sr[30];
  assign w_err      = rx_bit ^ w_pred;
  assign w_sr_rx    = {r_sr[29:0], rx_bit};
  assign w_win_wrap = &r_win_cnt;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state     <= S_HUNT;
      r_sr        <= '0;
      r_fill_cnt  <= '0;
      r_match_cnt <= '0;
      r_win_cnt   <= '0;
      r_err_win   <= '0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_next;
      r_sr        <= w_sr_next;
      r_fill_cnt  <= w_fill_cnt_next;
      r_match_cnt <= w_match_cnt_next;
      r_win_cnt   <= w_win_cnt_next;
      r_err_win   <= w_err_win_next;
      r_err_pulse <= w_err_pulse_next;
      r_err_count <= w_err_count_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_sr_next        = r_sr;
    w_fill_cnt_next  = r_fill_cnt;
    w_match_cnt_next = r_match_cnt;
    w_win_cnt_next   = r_win_cnt;
    w_err_win_next   = r_err_win;
    w_err_pulse_next = 1'b0;
    w_err_count_next = r_err_count;

    if (rx_valid) begin
      case (r_state)
        S_HUNT: begin
          w_sr_next = w_sr_rx;
          if (r_fill_cnt == 5'd30) begin
            w_fill_cnt_next = '0;
            if (w_sr_rx != 31'd0) begin
              w_state_next     = S_SYNC;
              w_match_cnt_next = '0;
            end
          end else begin
            w_fill_cnt_next = r_fill_cnt + 1'b1;
          end
        end

        S_SYNC: begin
          w_sr_next = w_sr_rx;
          // An all-zero register predicts zeros forever; never let it lock.
          if (w_sr_rx == 31'd0) begin
            w_state_next     = S_HUNT;
            w_fill_cnt_next  = '0;
            w_match_cnt_next = '0;
          end else if (w_err) begin
            w_match_cnt_next = '0;
          end else if (r_match_cnt == LOCK_LAST) begin
            w_state_next     = S_LOCKED;
            w_match_cnt_next = '0;
            w_win_cnt_next   = '0;
            w_err_win_next   = '0;
          end else begin
            w_match_cnt_next = r_match_cnt + 1'b1;
          end
        end

        S_LOCKED: begin
          // Free-run on the prediction so a line error is not fed back.
          w_sr_next        = {r_sr[29:0], w_pred};
          w_err_pulse_next = w_err;
          w_win_cnt_next   = r_win_cnt + 1'b1;
          if (w_err) begin
            if (r_err_count != 16'hFFFF) w_err_count_next = r_err_count + 1'b1;
            if (r_err_win == ERR_LAST) begin
              w_state_next    = S_HUNT;
              w_fill_cnt_next = '0;
              w_err_win_next  = '0;
            end else if (w_win_wrap) begin
              w_err_win_next = '0;
            end else begin
              w_err_win_next = r_err_win + 1'b1;
            end
          end else if (w_win_wrap) begin
            w_err_win_next = '0;
          end
        end

        default: begin
          w_state_next    = S_HUNT;
          w_fill_cnt_next = '0;
        end
      endcase
    end

    if (clear_err) w_err_count_next = '0;
  end

  assign locked    = (r_state == S_LOCKED);
  assign state     = r_state;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;

`ifdef PRBS31_CHECKER_BITCNT_EN
  logic [31:0] r_bit_count;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_bit_count <= '0;
    end else if (clear_err) begin
      r_bit_count <= '0;
    end else if (rx_valid && (r_state == S_LOCKED) && (r_bit_count != 32'hFFFF_FFFF)) begin
      r_bit_count <= r_bit_count + 1'b1;
    end
  end

  assign bit_count = r_bit_count;
`else
  assign bit_count = 32'd0;
`endif

endmodule

// File: tb/tb_prbs31_checker.sv
// Directed bench for prbs31_checker: acquisition, error counting, window loss-of-lock, clear and reset.
module tb_prbs31_checker;

  logic        clk;
  logic        rst_n;
  logic        rx_valid;
  logic        rx_bit;
  logic        clear_err;
  logic        locked;
  logic [1:0]  state;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [31:0] bit_count;

  logic [30:0] gen;
  int          checks;
  int          errors;

  prbs31_checker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_bit    (rx_bit),
    .clear_err (clear_err),
    .locked    (locked),
    .state     (state),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .bit_count (bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  // Drive one cycle with an explicit bit; returns 1 time unit after the edge.
  task automatic send_raw(input logic v, input logic b, input logic clr);
    rx_valid  = v;
    rx_bit    = b;
    clear_err = clr;
    @(posedge clk);
    #1;
    rx_valid  = 1'b0;
    clear_err = 1'b0;
  endtask

  // Drive one generator bit (optionally inverted); generator advances only when valid.
  task automatic send(input logic v, input logic flip, input logic clr);
    logic b;
    b = v ? (gen[30] ^ flip) : 1'($urandom_range(0, 1));
    send_raw(v, b, clr);
    if (v) gen = {gen[29:0], gen[30] ^ gen[27]};
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic lock_fresh(input string tag);
    pulse_reset();
    repeat (94) send(1'b1, 1'b0, 1'b0);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL %s_prelock locked=%0b want 0", tag, locked); end
    send(1'b1, 1'b0, 1'b0);
    checks++;
    if (locked !== 1'b1 || state !== 2'd2) begin
      errors++; $display("FAIL %s_lock locked=%0b state=%0d want 1/2", tag, locked, state);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; rx_valid = 1'b0; rx_bit = 1'b0; clear_err = 1'b0;
    repeat (2) @(posedge clk);
    send_raw(1'b1, 1'b1, 1'b0);
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %0b want 0", locked); end
    checks++;
    if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_err_pulse got %0b want 0", err_pulse); end
    checks++;
    if (err_count !== 16'd0) begin errors++; $display("FAIL reset_err_count got %0d want 0", err_count); end
    checks++;
    if (bit_count !== 32'd0) begin errors++; $display("FAIL reset_bit_count got %0d want 0", bit_count); end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    $display("test_reset done");
  endtask

  task automatic test_lock();
    int pulses;
    for (int i = 1; i <= 94; i++) begin
      send(1'b1, 1'b0, 1'b0);
      if (i == 30) begin
        checks++;
        if (state !== 2'd0) begin errors++; $display("FAIL hunt_fill30 state=%0d want 0", state); end
      end
      if (i == 31) begin
        checks++;
        if (state !== 2'd1) begin errors++; $display("FAIL hunt_fill31 state=%0d want 1", state); end
      end
    end
    checks++;
    if (locked !== 1'b0 || state !== 2'd1) begin
      errors++; $display("FAIL sync_94 locked=%0b state=%0d want 0/1", locked, state);
    end
    send(1'b1, 1'b0, 1'b0);
    checks++;
    if (locked !== 1'b1 || state !== 2'd2) begin
      errors++; $display("FAIL lock_95 locked=%0b state=%0d want 1/2", locked, state);
    end
    pulses = 0;
    for (int i = 0; i < 10000; i++) begin
      send(1'b1, 1'b0, 1'b0);
      if (err_pulse === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || err_count !== 16'd0 || locked !== 1'b1) begin
      errors++; $display("FAIL clean_10000 pulses=%0d err_count=%0d locked=%0b want 0/0/1", pulses, err_count, locked);
    end
`ifdef PRBS31_CHECKER_BITCNT_EN
    checks++;
    if (bit_count !== 32'd10000) begin errors++; $display("FAIL bit_count_clean got %0d want 10000", bit_count); end
`else
    checks++;
    if (bit_count !== 32'd0) begin errors++; $display("FAIL bit_count_tied got %0d want 0", bit_count); end
`endif
    $display("test_lock done");
  endtask

  task automatic test_single_flip();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 499; i++) begin
      send(1'b1, 1'b0, 1'b0);
      if (err_pulse === 1'b1) pulses++;
    end
    send(1'b1, 1'b1, 1'b0);
    checks++;
    if (err_pulse !== 1'b1) begin errors++; $display("FAIL flip_pulse got %0b want 1", err_pulse); end
    if (err_pulse === 1'b1) pulses++;
    send(1'b1, 1'b0, 1'b0);
    checks++;
    if (err_pulse !== 1'b0) begin errors++; $display("FAIL flip_pulse_end got %0b want 0", err_pulse); end
    for (int i = 0; i < 20; i++) begin
      send(1'b1, 1'b0, 1'b0);
      if (err_pulse === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || err_count !== 16'd1 || locked !== 1'b1) begin
      errors++; $display("FAIL single_flip pulses=%0d err_count=%0d locked=%0b want 1/1/1", pulses, err_count, locked);
    end
    $display("test_single_flip done");
  endtask

  task automatic test_valid_gap();
    for (int i = 0; i < 5; i++) begin
      send(1'b0, 1'b0, 1'b0);
      checks++;
      if (err_pulse !== 1'b0 || state !== 2'd2) begin
        errors++; $display("FAIL gap_%0d err_pulse=%0b state=%0d want 0/2", i, err_pulse, state);
      end
    end
    send(1'b1, 1'b0, 1'b0);
    checks++;
    if (err_count !== 16'd1 || err_pulse !== 1'b0) begin
      errors++; $display("FAIL gap_resume err_count=%0d err_pulse=%0b want 1/0", err_count, err_pulse);
    end
    $display("test_valid_gap done");
  endtask

  task automatic test_clear();
    send(1'b1, 1'b1, 1'b1);
    checks++;
    if (err_count !== 16'd0) begin errors++; $display("FAIL clear_err_count got %0d want 0", err_count); end
    checks++;
    if (err_pulse !== 1'b1 || state !== 2'd2) begin
      errors++; $display("FAIL clear_pulse_state err_pulse=%0b state=%0d want 1/2", err_pulse, state);
    end
`ifdef PRBS31_CHECKER_BITCNT_EN
    checks++;
    if (bit_count !== 32'd0) begin errors++; $display("FAIL clear_bit_count got %0d want 0", bit_count); end
    for (int i = 1; i <= 3; i++) begin
      send(1'b1, 1'b0, 1'b0);
      checks++;
      if (bit_count !== 32'(i)) begin errors++; $display("FAIL bit_count_after_clear got %0d want %0d", bit_count, i); end
    end
`endif
    $display("test_clear done");
  endtask

  task automatic test_burst();
    lock_fresh("burst");
    for (int i = 1; i <= 8; i++) begin
      send(1'b1, 1'b1, 1'b0);
      if (i == 7) begin
        checks++;
        if (state !== 2'd2) begin errors++; $display("FAIL burst_7th state=%0d want 2", state); end
      end
    end
    checks++;
    if (state !== 2'd0 || locked !== 1'b0 || err_count !== 16'd8) begin
      errors++; $display("FAIL burst_8th state=%0d locked=%0b err_count=%0d want 0/0/8", state, locked, err_count);
    end
    repeat (94) send(1'b1, 1'b0, 1'b0);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL burst_relock_94 locked=%0b want 0", locked); end
    send(1'b1, 1'b0, 1'b0);
    checks++;
    if (locked !== 1'b1 || err_count !== 16'd8) begin
      errors++; $display("FAIL burst_relock_95 locked=%0b err_count=%0d want 1/8", locked, err_count);
    end
    $display("test_burst done");
  endtask

  // Freshly locked: window bits 0..1023 form the first window.
  task automatic test_window_wrap();
    repeat (7) send(1'b1, 1'b1, 1'b0);
    repeat (1017) send(1'b1, 1'b0, 1'b0);
    repeat (7) send(1'b1, 1'b1, 1'b0);
    checks++;
    if (state !== 2'd2 || err_count !== 16'd22) begin
      errors++; $display("FAIL window_wrap state=%0d err_count=%0d want 2/22", state, err_count);
    end
    send(1'b1, 1'b1, 1'b0);
    checks++;
    if (state !== 2'd0 || err_count !== 16'd23) begin
      errors++; $display("FAIL window_limit state=%0d err_count=%0d want 0/23", state, err_count);
    end
    for (int i = 0; i < 20; i++) send(1'b1, 1'(i % 2), 1'b0);
    checks++;
    if (err_count !== 16'd23 || err_pulse !== 1'b0) begin
      errors++; $display("FAIL hunt_hold err_count=%0d err_pulse=%0b want 23/0", err_count, err_pulse);
    end
    $display("test_window_wrap done");
  endtask

  task automatic test_stuck_zero();
    logic left_hunt;
    pulse_reset();
    left_hunt = 1'b0;
    for (int i = 0; i < 200; i++) begin
      send_raw(1'b1, 1'b0, 1'b0);
      if (state !== 2'd0 || locked !== 1'b0) left_hunt = 1'b1;
    end
    checks++;
    if (left_hunt !== 1'b0) begin errors++; $display("FAIL stuck_zero left_hunt=%0b want 0", left_hunt); end
    $display("test_stuck_zero done");
  endtask

  task automatic test_reset_midlock();
    lock_fresh("midlock");
    send(1'b1, 1'b1, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (state !== 2'd0 || locked !== 1'b0 || err_pulse !== 1'b0 || err_count !== 16'd0 || bit_count !== 32'd0) begin
      errors++; $display("FAIL reset_midlock state=%0d locked=%0b err_pulse=%0b err_count=%0d bit_count=%0d want all 0",
                         state, locked, err_pulse, err_count, bit_count);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 1; i <= 95; i++) begin
      send(1'b1, 1'b0, 1'b0);
      if (i == 94) begin
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL midlock_relock_94 locked=%0b want 0", locked); end
      end
      send(1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (locked !== 1'b1 || err_count !== 16'd0) begin
      errors++; $display("FAIL midlock_relock_95 locked=%0b err_count=%0d want 1/0", locked, err_count);
    end
    $display("test_reset_midlock done");
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    gen       = 31'd1;
    rst_n     = 1'b1;
    rx_valid  = 1'b0;
    rx_bit    = 1'b0;
    clear_err = 1'b0;
    test_reset();
    test_lock();
    test_single_flip();
    test_valid_gap();
    test_clear();
    test_burst();
    test_window_wrap();
    test_stuck_zero();
    test_reset_midlock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prbs31_checker.md
PRBS31_CHECKER -- requirements
Module: prbs31_checker

Interface
REQ-001 Parameter LOCK_CNT, default 64: consecutive matching bits in SYNC required to enter LOCKED, range 1..255.
REQ-002 Parameter ERR_LIMIT, default 8: errors within one window that force loss of lock, range 1..255.
REQ-003 Parameter WINDOW, default 1024: loss-of-lock window length in valid bits, a power of two from 32 to 65536.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-high.
REQ-006 rx_valid  input  1  qualifies rx_bit; a bit is consumed only in cycles where it is high.
REQ-007 rx_bit  input  1  received serial PRBS31 bit, MSB-first from a generator with x[n] = x[n-28] ^ x[n-31].
REQ-008 clear_err  input  1  synchronous clear of err_count and bit_count.
REQ-009 locked  output  1  high while state is LOCKED.
REQ-010 state  output  2  HUNT=0, SYNC=1, LOCKED=2; 3 is never driven.
REQ-011 err_pulse  output  1  one-cycle pulse per bit error detected in LOCKED.
REQ-012 err_count  output  16  saturating count of bit errors detected in LOCKED.
REQ-013 bit_count  output  32  count of valid bits checked in LOCKED; see REQ-030.

Function
REQ-014 31-bit shift register sr: sr[0] is the newest bit; predicted bit p = sr[27] ^ sr[30]; on each valid bit, sr shifts left by one.
REQ-015 HUNT: rx_bit is shifted into sr[0]; a fill counter counts valid bits; after 31 valid bits, go to SYNC if sr is non-zero; otherwise restart the fill.
REQ-016 SYNC: rx_bit is shifted into sr[0]; each rx_bit == p increments the match counter; any mismatch clears the match counter and stays in SYNC.
REQ-017 SYNC: when the match counter reaches LOCK_CNT, go to LOCKED on that same edge; the window and error-in-window counters are cleared.
REQ-018 SYNC: if sr becomes all-zero, go to HUNT (guards against false lock on a stuck-zero line).
REQ-019 LOCKED: sr free-runs on p, not rx_bit, so a single line error is counted once and not tripled by feedback.
REQ-020 LOCKED: error e = rx_bit ^ p; err_pulse equals e, registered, high the cycle after the sampling edge; otherwise err_pulse is 0.
REQ-021 LOCKED: on e, err_count increments, saturating at 16'hFFFF, and the error-in-window counter increments.
REQ-022 LOCKED: the window counter counts valid bits modulo WINDOW; on wrap, the error-in-window counter is cleared.
REQ-023 LOCKED: when the error-in-window counter reaches ERR_LIMIT, go to HUNT on that edge and clear the fill counter; err_count holds.
REQ-024 Simultaneous error reaching ERR_LIMIT and window wrap: loss of lock wins.
REQ-025 clear_err concurrent with an error: the clear wins; err_count becomes 0, not 1. clear_err does not affect state.
REQ-026 rx_valid low: no state, shift register or counter changes; err_pulse is 0 in the following cycle.
REQ-027 locked and state are registered and change on the edge that makes the transition.

Reset
REQ-028 rst_n high asynchronously forces state=HUNT, sr=0, all counters 0, locked=0, err_pulse=0, err_count=0 and bit_count=0; these values hold while rst_n is high.
REQ-029 Reset asserted mid-lock discards lock; after release, a full HUNT fill (31 bits) plus LOCK_CNT matches is required to relock.

Configuration
REQ-030 Macro PRBS31_CHECKER_BITCNT_EN: when defined, bit_count increments on each valid bit in LOCKED, saturating at 32'hFFFFFFFF and cleared by clear_err/reset; when undefined, bit_count is tied to 32'd0 and no counter is built.

Verification
REQ-031 Clean stream: generator seeded with 31'd1, one valid bit per cycle, defaults -> locked rises after 31+64 valid bits; err_count stays 0 for 10000 bits.
REQ-032 Single flip: invert one bit at 500 bits after lock -> exactly one err_pulse, one cycle after that bit; err_count=1; locked stays 1.
REQ-033 Burst: invert 8 bits within 1024 bits after lock -> state=HUNT on the 8th error edge; err_count=8; relocks after 95 further clean bits.
REQ-034 Stuck-zero input for 200 bits after reset -> state never leaves HUNT; locked=0.
REQ-035 clear_err asserted on an error cycle -> err_count=0; with PRBS31_CHECKER_BITCNT_EN, bit_count=0 and then counts 1,2,3... on the following valid bits.
REQ-036 rst_n pulsed while LOCKED with rx_valid toggling 50% -> all outputs 0 immediately; relock after 95 valid bits.
